// File: rtl/mips_mem_responder_pkg.sv
// Shared definitions for the MIPS unified memory responder: FSM encodings,
// word geometry, default timing and the access-fault check.
package mips_mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef logic [31:0] word_t;

   localparam int WORD_BYTES          = 4;
   localparam int ADDR_LSB            = 2;
   localparam int DEFAULT_WAIT_CYCLES = 2;
   localparam int DEFAULT_DEPTH_WORDS = 256;

   localparam int    INIT_IMAGE_WORDS = 1;
   localparam word_t INIT_IMAGE [INIT_IMAGE_WORDS] = '{32'h2008_0005};

   // Misaligned addresses and word indices beyond the array both fault.
   function automatic logic addr_fault(input logic [31:0] addr, input int unsigned depth);
      logic [31:0] widx;
      widx = {2'b00, addr[31:ADDR_LSB]};
      return (addr[ADDR_LSB-1:0] != '0) || (widx >= depth);
   endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// Request/response bus between the multicycle MIPS core (master) and the
// unified memory responder (slave).
interface mips_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  ready, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output ready, rdata, err
    );
endinterface

// File: rtl/mips_mem_responder_array.sv
// Word storage with byte-enabled synchronous write and combinational read.
// Contents load from the boot image when MIPS_MEM_INIT_EN is defined, else all zero.
module mips_mem_array
   import mips_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
`ifdef MIPS_MEM_INIT_EN
   parameter string INIT_FILE = "program.hex",
`endif
   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_W-1:0]      widx,
   input  word_t                 wdata,
   input  logic [WORD_BYTES-1:0] wstrb,
   input  logic [IDX_W-1:0]      ridx,
   output word_t                 rdata
);

   // Not touched by reset: the image survives a core reset.
   word_t mem_q [DEPTH_WORDS] = '{default: '0};

`ifdef MIPS_MEM_INIT_EN
   initial begin
      for (int i = 0; i < INIT_IMAGE_WORDS; i++) begin
         if (i < DEPTH_WORDS) begin
            mem_q[i] = INIT_IMAGE[i];
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < WORD_BYTES; b++) begin
            if (wstrb[b]) begin
               mem_q[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   assign rdata = mem_q[ridx];

endmodule

// File: rtl/mips_mem_responder.sv
// Unified instruction/data memory slave: one access at a time, WAIT_CYCLES wait
// states, one-cycle ready pulse. Optional image load via MIPS_MEM_INIT_EN.
//   state | meaning
//   IDLE  | waiting for req; request fields captured on acceptance
//   WAIT  | counting down wait states, bus inputs ignored
//   RESP  | ready pulse; a write commits on the edge that ends this state
module mips_mem_responder
    import mips_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
`ifdef MIPS_MEM_INIT_EN
    ,
    parameter string INIT_FILE = "program.hex"
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_mem_responder_if.slave  bus
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [31:0]           addr_q, addr_d;
    word_t                 wdata_q, wdata_d;
    logic [WORD_BYTES-1:0] wstrb_q, wstrb_d;
    logic                  ready_q, ready_d;
    word_t                 rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  enter_resp;
    logic [31:0]           acc_addr;
    logic                  acc_we;
    logic                  acc_fault;
    logic                  arr_we;
    word_t                 arr_rdata;

    // With zero wait states the response is formed on the accepting edge,
    // so the live bus fields stand in for the not-yet-captured ones.
    assign acc_addr  = (state_q == IDLE) ? bus.addr : addr_q;
    assign acc_we    = (state_q == IDLE) ? bus.we   : we_q;
    assign acc_fault = addr_fault(acc_addr, unsigned'(DEPTH_WORDS));
    assign arr_we    = (state_q == RESP) && we_q && !err_q;

    mips_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
`ifdef MIPS_MEM_INIT_EN
        ,
        .INIT_FILE   (INIT_FILE)
`endif
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .widx  (addr_q[IDX_W+ADDR_LSB-1:ADDR_LSB]),
        .wdata (wdata_q),
        .wstrb (wstrb_q),
        .ridx  (acc_addr[IDX_W+ADDR_LSB-1:ADDR_LSB]),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        ready_d    = 1'b0;
        rdata_d    = '0;
        err_d      = 1'b0;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    wstrb_d = bus.wstrb;
                    if (WAIT_CYCLES > 0) begin
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                        state_d = WAIT;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_resp) begin
            ready_d = 1'b1;
            err_d   = acc_fault;
            rdata_d = (!acc_we && !acc_fault) ? arr_rdata : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: a vector table on a two-wait-state
// instance plus reset and zero-wait back-to-back sequences.
module tb_mips_mem_responder;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mips_mem_responder_if bus_if ();
    mips_mem_responder_if bus0_if ();

    mips_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    mips_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0_if)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [31:0] EXP_WORD0 =
`ifdef MIPS_MEM_INIT_EN
        32'h2008_0005;
`else
        32'h0000_0000;
`endif

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one access on the two-wait-state instance; returns response and latency.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic e,
                          output int lat);
        bus_if.req   = 1'b1;
        bus_if.we    = w;
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.wstrb = s;
        lat = -1;
        rd  = 32'hx;
        e   = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus_if.ready === 1'b1) begin
                lat = i;
                rd  = bus_if.rdata;
                e   = bus_if.err;
                break;
            end
        end
        bus_if.req = 1'b0;
        @(negedge clk);
        check32("ready_pulse_width", {31'b0, bus_if.ready}, 32'd0);
    endtask

    task automatic access0(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output logic e,
                           output int lat);
        bus0_if.req   = 1'b1;
        bus0_if.we    = w;
        bus0_if.addr  = a;
        bus0_if.wdata = d;
        bus0_if.wstrb = s;
        lat = -1;
        rd  = 32'hx;
        e   = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus0_if.ready === 1'b1) begin
                lat = i;
                rd  = bus0_if.rdata;
                e   = bus0_if.err;
                break;
            end
        end
        bus0_if.req = 1'b0;
        @(negedge clk);
        check32("w0_ready_pulse_width", {31'b0, bus0_if.ready}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;

        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,          4'h0, EXP_WORD0,    1'b0});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,          4'h0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,          4'h0, 32'h11BB_33DD, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,          4'h0, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,          4'h0, 32'hCAFE_F00D, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0021, 32'h0000_0000, 4'hF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,          4'h0, 32'h11BB_33DD, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,          4'h0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0,          4'h0, 32'hA5A5_A5A5, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,          4'h0, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h0000_0014, 32'h1234_5678, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_0014, 32'h0,          4'h0, 32'h1234_5678, 1'b0});

        reset = 1'b1;
        bus_if.req = 1'b0;  bus_if.we = 1'b0;  bus_if.addr = '0;  bus_if.wdata = '0;  bus_if.wstrb = '0;
        bus0_if.req = 1'b0; bus0_if.we = 1'b0; bus0_if.addr = '0; bus0_if.wdata = '0; bus0_if.wstrb = '0;
        @(negedge clk);
        @(negedge clk);
        check32("reset_ready", {31'b0, bus_if.ready}, 32'd0);
        check32("reset_rdata", bus_if.rdata, 32'd0);
        check32("reset_err", {31'b0, bus_if.err}, 32'd0);
        check32("reset_w0_ready", {31'b0, bus0_if.ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[k]) begin
            access(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].wstrb, rd, e, lat);
            check32($sformatf("vec%0d_latency", k), 32'(lat), 32'd3);
            check32($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
            check32($sformatf("vec%0d_err", k), {31'b0, e}, {31'b0, vecs[k].exp_err});
        end

        // Reset during WAIT of a write: write is dropped, then a request held
        // across reset release is accepted on the first edge after release.
        access(1'b1, 32'h8, 32'h0BAD_CAFE, 4'hF, rd, e, lat);
        check32("pre_write_err", {31'b0, e}, 32'd0);
        bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.addr = 32'h8;
        bus_if.wdata = 32'h5555_5555; bus_if.wstrb = 4'hF;
        @(negedge clk);
        check32("mid_write_ready", {31'b0, bus_if.ready}, 32'd0);
        reset = 1'b1;
        #1;
        check32("async_reset_ready", {31'b0, bus_if.ready}, 32'd0);
        bus_if.we = 1'b0;
        @(negedge clk);
        check32("in_reset_ready_a", {31'b0, bus_if.ready}, 32'd0);
        @(negedge clk);
        check32("in_reset_ready_b", {31'b0, bus_if.ready}, 32'd0);
        reset = 1'b0;
        lat = -1;
        rd  = 32'hx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus_if.ready === 1'b1) begin
                lat = i;
                rd  = bus_if.rdata;
                break;
            end
        end
        bus_if.req = 1'b0;
        check32("release_latency", 32'(lat), 32'd3);
        check32("aborted_write_kept_old", rd, 32'h0BAD_CAFE);
        @(negedge clk);

        // Zero-wait instance: single accesses, then back-to-back reads.
        access0(1'b1, 32'h0, 32'h0101_0101, 4'hF, rd, e, lat);
        check32("w0_write0_latency", 32'(lat), 32'd1);
        access0(1'b1, 32'h4, 32'h0202_0202, 4'hF, rd, e, lat);
        check32("w0_write4_latency", 32'(lat), 32'd1);
        check32("w0_write4_err", {31'b0, e}, 32'd0);
        bus0_if.req = 1'b1; bus0_if.we = 1'b0; bus0_if.addr = 32'h0;
        @(negedge clk);
        check32("b2b_first_ready", {31'b0, bus0_if.ready}, 32'd1);
        check32("b2b_first_rdata", bus0_if.rdata, 32'h0101_0101);
        bus0_if.addr = 32'h4;
        @(negedge clk);
        check32("b2b_idle_gap", {31'b0, bus0_if.ready}, 32'd0);
        @(negedge clk);
        check32("b2b_second_ready", {31'b0, bus0_if.ready}, 32'd1);
        check32("b2b_second_rdata", bus0_if.rdata, 32'h0202_0202);
        bus0_if.req = 1'b0;
        @(negedge clk);
        check32("b2b_end_ready", {31'b0, bus0_if.ready}, 32'd0);
        access0(1'b0, 32'h0000_0402, 32'h0, 4'h0, rd, e, lat);
        check32("w0_fault_latency", 32'(lat), 32'd1);
        check32("w0_fault_err", {31'b0, e}, 32'd1);
        check32("w0_fault_rdata", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no completion, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
